// File: rtl/traffic_light_intersection_ctrl.sv
// Two-approach intersection controller: NS/EW green-yellow-all-red sequencing
// with programmable durations, latched pedestrian walk phase, flashing-yellow
// night mode and a global pause enable.
module traffic_light_intersection_ctrl #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] green_time,
  input  logic [CNT_W-1:0] yellow_time,
  input  logic [CNT_W-1:0] red_clear_time,
  input  logic [CNT_W-1:0] walk_time,
  input  logic             flash_mode,
  input  logic             ped_req,
  output logic             ped_ack,
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic             walk,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  localparam int unsigned     FC_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_HALF - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  timer, timer_n;
  logic              pending, pending_n;
  logic              ret_ew, ret_ew_n;     // walk returns to EW_GREEN when set
  logic              flash_bit, flash_bit_n;
  logic [FC_W-1:0]   flash_cnt, flash_cnt_n;
  logic              ack_n;

  // A duration of zero is treated as one cycle
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // State, timer, request latch and flash counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ALL_RED_B;
      timer     <= '0;
      pending   <= 1'b0;
      ret_ew    <= 1'b0;
      flash_bit <= 1'b0;
      flash_cnt <= '0;
      ped_ack   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      pending   <= pending_n;
      ret_ew    <= ret_ew_n;
      flash_bit <= flash_bit_n;
      flash_cnt <= flash_cnt_n;
      ped_ack   <= ack_n;
    end
  end

  // Next-state, timer reload and pedestrian/flash bookkeeping
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    pending_n   = pending | ped_req;
    ret_ew_n    = ret_ew;
    flash_bit_n = flash_bit;
    flash_cnt_n = flash_cnt;
    ack_n       = 1'b0;
    if (enable) begin
      if (state == FLASH) begin
        if (!flash_mode) begin
          state_n = ALL_RED_B;
          timer_n = load_val(red_clear_time);
        end else if (flash_cnt == FC_LAST) begin
          flash_cnt_n = '0;
          flash_bit_n = ~flash_bit;
        end else begin
          flash_cnt_n = flash_cnt + 1'b1;
        end
      end else if (timer != '0) begin
        timer_n = timer - 1'b1;
      end else begin
        unique case (state)
          NS_GREEN: begin
            state_n = NS_YELLOW;
            timer_n = load_val(yellow_time);
          end
          NS_YELLOW: begin
            state_n = ALL_RED_A;
            timer_n = load_val(red_clear_time);
          end
          EW_GREEN: begin
            state_n = EW_YELLOW;
            timer_n = load_val(yellow_time);
          end
          EW_YELLOW: begin
            state_n = ALL_RED_B;
            timer_n = load_val(red_clear_time);
          end
          ALL_RED_A, ALL_RED_B: begin
            if (flash_mode) begin
              state_n     = FLASH;
              timer_n     = '0;
              flash_bit_n = 1'b1;
              flash_cnt_n = '0;
            end else if (pending) begin
              // A request arriving on the serving edge stays pending
              state_n   = PED_WALK;
              timer_n   = load_val(walk_time);
              ret_ew_n  = (state == ALL_RED_A);
              ack_n     = 1'b1;
              pending_n = ped_req;
            end else begin
              state_n = (state == ALL_RED_A) ? EW_GREEN : NS_GREEN;
              timer_n = load_val(green_time);
            end
          end
          PED_WALK: begin
            state_n = ret_ew ? EW_GREEN : NS_GREEN;
            timer_n = load_val(green_time);
          end
          default: ;
        endcase
      end
    end
  end

  // Moore lamp decode from the state register
  always_comb begin
    ns_red    = 1'b0;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b0;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    unique case (state)
      NS_GREEN:  begin ns_green  = 1'b1; ew_red = 1'b1; end
      NS_YELLOW: begin ns_yellow = 1'b1; ew_red = 1'b1; end
      EW_GREEN:  begin ew_green  = 1'b1; ns_red = 1'b1; end
      EW_YELLOW: begin ew_yellow = 1'b1; ns_red = 1'b1; end
      ALL_RED_A, ALL_RED_B: begin ns_red = 1'b1; ew_red = 1'b1; end
      PED_WALK:  begin ns_red = 1'b1; ew_red = 1'b1; walk = 1'b1; end
      FLASH:     begin ns_yellow = flash_bit; ew_yellow = flash_bit; end
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_intersection_ctrl.sv
// Bench for traffic_light_intersection_ctrl: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural reference model.
module tb_traffic_light_intersection_ctrl;

  localparam int FLASH_HALF = 4;

  logic       clk = 1'b0;
  logic       reset, enable, flash_mode, ped_req;
  logic [7:0] green_time, yellow_time, red_clear_time, walk_time;
  logic       ped_ack, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;
  int ack_seen = 0;

  // Reference model: phase number, cycles spent, duration chosen at entry
  int m_phase, m_el, m_dur, m_ret, m_fel;
  bit m_pend, m_ack;

  traffic_light_intersection_ctrl #(.CNT_W(8), .FLASH_HALF(FLASH_HALF)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .green_time(green_time), .yellow_time(yellow_time),
    .red_clear_time(red_clear_time), .walk_time(walk_time),
    .flash_mode(flash_mode), .ped_req(ped_req), .ped_ack(ped_ack),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
  function automatic logic [6:0] exp_lamps(input int p, input bit fb);
    case (p)
      0:       return 7'b0011000;
      1:       return 7'b0101000;
      3:       return 7'b1000010;
      4:       return 7'b1000100;
      6:       return 7'b1001001;
      7:       return {1'b0, fb, 2'b00, fb, 2'b00};
      default: return 7'b1001000;
    endcase
  endfunction

  task automatic m_enter(input int p, input logic [7:0] d);
    m_phase = p;
    m_el    = 0;
    m_dur   = (d == 0) ? 1 : int'(d);
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    bit pend_next;
    bit ack_next;
    if (reset) begin
      m_phase = 5; m_el = 0; m_dur = 1; m_pend = 0; m_ret = 0; m_fel = 0; m_ack = 0;
      return;
    end
    pend_next = m_pend | ped_req;
    ack_next  = 0;
    if (enable) begin
      if (m_phase == 7) begin
        if (!flash_mode) m_enter(5, red_clear_time);
        else m_fel++;
      end else if (m_el + 1 >= m_dur) begin
        case (m_phase)
          0: m_enter(1, yellow_time);
          1: m_enter(2, red_clear_time);
          3: m_enter(4, yellow_time);
          4: m_enter(5, red_clear_time);
          6: m_enter(m_ret, green_time);
          default: begin
            if (flash_mode) begin
              m_phase = 7; m_fel = 0;
            end else if (m_pend) begin
              m_ret = (m_phase == 2) ? 3 : 0;
              m_enter(6, walk_time);
              ack_next  = 1;
              pend_next = ped_req;
            end else begin
              m_enter((m_phase == 2) ? 3 : 0, green_time);
            end
          end
        endcase
      end else begin
        m_el++;
      end
    end
    m_pend = pend_next;
    m_ack  = ack_next;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("phase", {5'd0, phase}, m_phase[7:0]);
    chk("lamps", {1'b0, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk},
        {1'b0, exp_lamps(m_phase, ((m_fel / FLASH_HALF) % 2) == 0)});
    chk("ped_ack", {7'd0, ped_ack}, {7'd0, m_ack});
    if (m_phase != 7) begin
      chk("ns_onehot", 8'($countones({ns_red, ns_yellow, ns_green})), 8'd1);
      chk("ew_onehot", 8'($countones({ew_red, ew_yellow, ew_green})), 8'd1);
    end
    if (ped_ack === 1'b1) ack_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int p, input int max_cycles);
    int n = 0;
    while (m_phase != p && n < max_cycles) begin
      tick();
      n++;
    end
    chk("reach_phase", {5'd0, phase}, p[7:0]);
  endtask

  initial begin
    reset = 1; enable = 1; flash_mode = 0; ped_req = 0;
    green_time = 3; yellow_time = 2; red_clear_time = 1; walk_time = 2;
    m_phase = 5; m_el = 0; m_dur = 1; m_pend = 0; m_ret = 0; m_fel = 0; m_ack = 0;

    // Reset state, then two plain 12-cycle periods
    run(2);
    reset = 0;
    run(24);

    // Pedestrian request during NS_GREEN, served after ALL_RED_A
    run_until(0, 20);
    ped_req = 1; tick(); ped_req = 0;
    ack_seen = 0;
    run_until(3, 30);
    chk("ack_once", ack_seen[7:0], 8'd1);
    run(3);

    // Zero durations, then green change in the middle of NS_GREEN
    green_time = 0; yellow_time = 0;
    run(14);
    green_time = 3; yellow_time = 2;
    run_until(0, 20);
    tick();
    green_time = 7;
    run(25);
    green_time = 3;

    // Flash mode with a pending request, then exit into the walk
    run_until(3, 30);
    ped_req = 1; tick(); ped_req = 0;
    flash_mode = 1;
    run_until(7, 30);
    run(10);
    flash_mode = 0;
    run_until(0, 20);

    // Pause in NS_YELLOW with a request latched during the pause
    run_until(1, 30);
    enable = 0;
    ped_req = 1; tick(); ped_req = 0;
    run(4);
    enable = 1;
    run_until(6, 40);
    run(5);

    // Reset in the first walk cycle discards everything
    ped_req = 1; tick(); ped_req = 0;
    run_until(6, 40);
    reset = 1; tick(); reset = 0;
    run(20);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      enable  = ($urandom_range(0, 9) != 0);
      ped_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) flash_mode = ~flash_mode;
      if ($urandom_range(0, 15) == 0) green_time     = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) yellow_time    = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) red_clear_time = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) walk_time      = 8'($urandom_range(0, 4));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
